// File: rtl/fifo_flags_if.sv
// fifo_flags_if: handshake/data bundle for fifo_flags.
//   Producer side : wr_en, din, full, almost_full
//   Consumer side : rd_en, dout, dout_valid, empty, almost_empty
//   Status        : count, overflow, underflow
// Modports:
//   master - the user of the FIFO (drives wr_en/din/rd_en, observes the rest)
//   slave  - the FIFO itself
// data_width/fifo_depth must match the parameters of the attached fifo_flags.
interface fifo_flags_if #(
  parameter int data_width = 8,
  parameter int fifo_depth = 32
);
  localparam int addr_width = $clog2(fifo_depth);

  logic                  wr_en;
  logic [data_width-1:0] din;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [data_width-1:0] dout;
  logic                  dout_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [addr_width:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, din, rd_en,
    input  full, almost_full, dout, dout_valid, empty, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output full, almost_full, dout, dout_valid, empty, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flags.sv
// fifo_flags: parametrised synchronous FIFO with occupancy count,
// programmable almost-full/almost-empty flags and optional first-word-
// fall-through (FWFT) read mode.
//
// Parameters:
//   data_width          word width
//   fifo_depth          capacity in words (power of two, >= 4)
//   addr_width          derived storage index width; leave at default
//   fwft                0 = registered read, 1 = first-word-fall-through
//   almost_full_level   almost_full  when count >= level
//   almost_empty_level  almost_empty when count <= level
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fifo_flags_if.slave: wr_en/din/full/almost_full,
//          rd_en/dout/dout_valid/empty/almost_empty, count,
//          overflow/underflow
//
// Build option:
//   FIFO_ERR_FLAGS_EN - when defined, overflow/underflow are sticky error
//                       flags cleared only by rst; otherwise tied to 0.
module fifo_flags #(
  parameter int data_width         = 8,
  parameter int fifo_depth         = 32,
  parameter int addr_width         = $clog2(fifo_depth),
  parameter bit fwft               = 1'b0,
  parameter int almost_full_level  = fifo_depth - 4,
  parameter int almost_empty_level = 4
) (
  input  logic          clk,
  input  logic          rst,
  fifo_flags_if.slave   bus
);

  localparam int CW = addr_width + 1;
  localparam logic [addr_width:0] DEPTH_C = CW'(fifo_depth);
  localparam logic [addr_width:0] AF_C    = CW'(almost_full_level);
  localparam logic [addr_width:0] AE_C    = CW'(almost_empty_level);

  // Storage is deliberately not reset; reset only discards it logically.
  logic [data_width-1:0] mem [fifo_depth];

  logic [addr_width:0]   wr_ptr;
  logic [addr_width:0]   rd_ptr;
  logic [addr_width:0]   count_q;
  logic [data_width-1:0] dout_q;
  logic                  dout_valid_q;

  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic rd_acc;
  logic mem_empty;
  logic mem_pop;
  logic mem_we;
  logic bypass;
  logic refill;

  // Flags come from the registered count, so accept decisions use the
  // pre-edge state.
  assign full_w    = (count_q == DEPTH_C);
  assign empty_w   = (count_q == '0);
  assign wr_acc    = bus.wr_en && !full_w;
  assign rd_acc    = bus.rd_en && !empty_w;
  assign mem_empty = (wr_ptr == rd_ptr);

  // In FWFT mode the output register holds the head word and is part of
  // the capacity. It refills whenever it is popped or empty: from storage
  // if storage holds anything, otherwise straight from din (bypass), which
  // gives the same one-edge write-to-visible latency as standard mode.
  always_comb begin
    refill  = 1'b0;
    mem_pop = 1'b0;
    bypass  = 1'b0;
    if (fwft) begin
      refill  = rd_acc || !dout_valid_q;
      mem_pop = refill && !mem_empty;
      bypass  = wr_acc && refill && mem_empty;
    end else begin
      mem_pop = rd_acc;
    end
    mem_we = wr_acc && !bypass;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr[addr_width-1:0]] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (mem_we) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (mem_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (fwft) begin
      if (mem_pop) begin
        dout_q       <= mem[rd_ptr[addr_width-1:0]];
        dout_valid_q <= 1'b1;
      end else if (bypass) begin
        dout_q       <= bus.din;
        dout_valid_q <= 1'b1;
      end else if (rd_acc) begin
        dout_valid_q <= 1'b0;
      end
    end else begin
      dout_valid_q <= rd_acc;
      if (rd_acc) begin
        dout_q <= mem[rd_ptr[addr_width-1:0]];
      end
    end
  end

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky: set on the attempt regardless of acceptance, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_w) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && empty_w) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule
